amstrad_ram_arbiter: RTL and testbench

Shares one 16-bit external memory port between the CPU and the video fetch of the Amstrad motherboard. CPU accesses arrive as byte-wide read/write strobes on the 23-bit banked address from the MMU. Video fetches are 16-bit words addressed by the 15-bit CRTC/gate-array address. The block sits directly downstream of the motherboard. It returns `cpu_din` and `vram_din` to it, and drives a req/ack memory controller.

---
 rtl/amstrad_mem_pkg.sv | 18 +
 rtl/amstrad_ram_arbiter.sv | 127 ++++++++++++
 tb/tb_amstrad_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/amstrad_mem_pkg.sv
// rtl/amstrad_mem_pkg.sv - shared arbiter state type and byte-lane helpers
package amstrad_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2
    } arb_state_t;

    localparam logic [1:0] BE_EVEN = 2'b01;
    localparam logic [1:0] BE_ODD  = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    function automatic logic [1:0] lane_be(input logic addr0);
        return addr0 ? BE_ODD : BE_EVEN;
    endfunction

endpackage

// File: rtl/amstrad_ram_arbiter.sv
// rtl/amstrad_ram_arbiter.sv - CPU/video arbiter for one 16-bit req/ack memory port
module amstrad_ram_arbiter
    import amstrad_mem_pkg::*;
#(
    parameter int              AW        = 23,
    parameter logic [AW-1:0]   VRAM_BASE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_din,
    output logic              cpu_ready,
    input  logic              vid_strobe,
    input  logic [14:0]       vram_addr,
    output logic [15:0]       vram_din,
    output logic              vid_overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    arb_state_t    state, state_nx;
    logic          cpu_rd_q, cpu_wr_q;
    logic          cpu_pend, cpu_we_c;
    logic [AW-1:0] cpu_addr_c;
    logic [7:0]    cpu_wdata_c;
    logic          vid_pend;
    logic [14:0]   vaddr;

    logic rd_rise, wr_rise, ack_vid, ack_cpu, cpu_take;

    assign rd_rise  = cpu_rd & ~cpu_rd_q;
    assign wr_rise  = cpu_wr & ~cpu_wr_q;
    assign ack_vid  = mem_ack && (state == VID);
    assign ack_cpu  = mem_ack && (state == CPU);
    // An edge landing on the completing cycle starts the next access.
    assign cpu_take = (rd_rise | wr_rise) && (!cpu_pend || ack_cpu);
    assign cpu_ready = ~cpu_pend;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (vid_pend)
                    state_nx = VID;
                else if (cpu_pend)
                    state_nx = CPU;
            end
            VID:     if (mem_ack) state_nx = IDLE;
            CPU:     if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cpu_rd_q    <= 1'b0;
            cpu_wr_q    <= 1'b0;
            cpu_pend    <= 1'b0;
            cpu_we_c    <= 1'b0;
            cpu_addr_c  <= '0;
            cpu_wdata_c <= 8'h00;
            vid_pend    <= 1'b0;
            vaddr       <= 15'h0000;
            vid_overrun <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= 2'b00;
            mem_wdata   <= 16'h0000;
            cpu_din     <= 8'hFF;
            vram_din    <= 16'h0000;
        end else begin
            state    <= state_nx;
            cpu_rd_q <= cpu_rd;
            cpu_wr_q <= cpu_wr;

            if (ack_cpu)
                cpu_pend <= 1'b0;
            if (cpu_take) begin
                cpu_pend    <= 1'b1;
                cpu_we_c    <= wr_rise;
                cpu_addr_c  <= cpu_addr;
                cpu_wdata_c <= cpu_wdata;
            end

            if (ack_vid)
                vid_pend <= 1'b0;
            if (vid_strobe) begin
                vid_pend <= 1'b1;
                vaddr    <= vram_addr;
                if (vid_pend && !ack_vid)
                    vid_overrun <= 1'b1;
            end

            if (state == IDLE && state_nx == VID) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= VRAM_BASE + {{(AW-16){1'b0}}, vaddr, 1'b0};
                mem_be   <= BE_WORD;
            end else if (state == IDLE && state_nx == CPU) begin
                mem_req   <= 1'b1;
                mem_we    <= cpu_we_c;
                mem_addr  <= cpu_addr_c;
                mem_be    <= lane_be(cpu_addr_c[0]);
                mem_wdata <= {cpu_wdata_c, cpu_wdata_c};
            end else if (ack_vid || ack_cpu) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end

            if (ack_vid)
                vram_din <= mem_rdata;
            if (ack_cpu && !cpu_we_c)
                cpu_din <= cpu_addr_c[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        end
    end

endmodule

// File: tb/tb_amstrad_ram_arbiter.sv
// tb/tb_amstrad_ram_arbiter.sv - scoreboard bench for amstrad_ram_arbiter
module tb_amstrad_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic        vid_strobe;
    logic [14:0] vram_addr;
    logic [15:0] vram_din;
    logic        vid_overrun;
    logic        mem_req, mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    logic        vid_strobe1;
    logic [14:0] vram_addr1;
    logic [7:0]  cpu_din1;
    logic        cpu_ready1;
    logic [15:0] vram_din1;
    logic        vid_overrun1;
    logic        mem_req1, mem_we1;
    logic [22:0] mem_addr1;
    logic [1:0]  mem_be1;
    logic [15:0] mem_wdata1;
    logic        mem_ack1;

    always #5 clk = ~clk;

    amstrad_ram_arbiter #(.AW(23), .VRAM_BASE(23'h000000)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_din(cpu_din), .cpu_ready(cpu_ready),
        .vid_strobe(vid_strobe), .vram_addr(vram_addr), .vram_din(vram_din),
        .vid_overrun(vid_overrun), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    amstrad_ram_arbiter #(.AW(23), .VRAM_BASE(23'h040000)) dut_base (
        .clk(clk), .reset(reset), .cpu_addr(23'h000000), .cpu_rd(1'b0), .cpu_wr(1'b0),
        .cpu_wdata(8'h00), .cpu_din(cpu_din1), .cpu_ready(cpu_ready1),
        .vid_strobe(vid_strobe1), .vram_addr(vram_addr1), .vram_din(vram_din1),
        .vid_overrun(vid_overrun1), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_be(mem_be1), .mem_wdata(mem_wdata1), .mem_rdata(16'h0000), .mem_ack(mem_ack1)
    );

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_txn(input logic we, input logic [22:0] addr, input logic [1:0] be,
                            input logic [15:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    // Waits for a request, scores it against the queue head, acks after lat cycles.
    task automatic serve(input int lat, input logic [15:0] rdata, output int waited);
        txn_t t;
        waited = 0;
        while (!mem_req && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_req) begin
            check("req_timeout", 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            check("sb_unexpected_req", 32'(exp_q.size()), 32'd1);
        end else begin
            t = exp_q.pop_front();
            check("sb_we", 32'(mem_we), 32'(t.we));
            check("sb_addr", 32'(mem_addr), 32'(t.addr));
            check("sb_be", 32'(mem_be), 32'(t.be));
            if (t.we)
                check("sb_wdata", 32'(mem_wdata), 32'(t.wdata));
            repeat (lat) @(negedge clk);
            mem_rdata = rdata;
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack   = 1'b0;
            check("req_drop_after_ack", 32'(mem_req), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, cnt;
        logic prev;
        reset = 1'b1; cpu_addr = '0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = 0;
        vid_strobe = 0; vram_addr = 0; mem_rdata = 0; mem_ack = 0;
        vid_strobe1 = 0; vram_addr1 = 0; mem_ack1 = 0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_cpu_din", 32'(cpu_din), 32'hFF);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_vram_din", 32'(vram_din), 32'd0);
        check("rst_overrun", 32'(vid_overrun), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // CPU read at an odd address, acked 3 cycles after the request rises
        cpu_addr = 23'h004001; cpu_rd = 1;
        push_txn(1'b0, 23'h004001, 2'b10, 16'h0000);
        cnt = 0;
        fork
            serve(3, 16'hA55A, waited);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (!cpu_ready) cnt++;
            end
        join
        cpu_rd = 0;
        check("rd_cpu_din", 32'(cpu_din), 32'hA5);
        check("rd_ready_low_cycles", 32'(cnt), 32'd5);
        check("rd_req_latency", 32'(waited), 32'd2);
        @(negedge clk);

        // Video strobe and CPU write rising together
        vid_strobe = 1; vram_addr = 15'h1234;
        cpu_wr = 1; cpu_addr = 23'h010000; cpu_wdata = 8'h3C;
        push_txn(1'b0, 23'h002468, 2'b11, 16'h0000);
        push_txn(1'b1, 23'h010000, 2'b01, 16'h3C3C);
        @(negedge clk);
        vid_strobe = 0;
        serve(1, 16'hBEEF, waited);
        check("sim_vram_din", 32'(vram_din), 32'hBEEF);
        serve(1, 16'h0000, waited);
        check("sim_idle_gap", 32'(waited), 32'd1);
        cpu_wr = 0;
        check("sim_cpu_din_kept", 32'(cpu_din), 32'hA5);
        check("sim_no_overrun", 32'(vid_overrun), 32'd0);
        @(negedge clk);

        // Two strobes queued behind a long CPU read
        cpu_addr = 23'h000100; cpu_rd = 1;
        push_txn(1'b0, 23'h000100, 2'b01, 16'h0000);
        fork
            serve(6, 16'h1122, waited);
            begin
                @(negedge clk);
                @(negedge clk);
                vid_strobe = 1; vram_addr = 15'h0001;
                @(negedge clk);
                vram_addr = 15'h0002;
                @(negedge clk);
                vid_strobe = 0;
            end
        join
        cpu_rd = 0;
        push_txn(1'b0, 23'h000004, 2'b11, 16'h0000);
        serve(1, 16'h7777, waited);
        check("ovr_flag", 32'(vid_overrun), 32'd1);
        check("ovr_vram_din", 32'(vram_din), 32'h7777);
        check("ovr_cpu_din", 32'(cpu_din), 32'h22);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) cnt++;
        end
        check("ovr_single_fetch", 32'(cnt), 32'd0);

        // Read level held for 20 cycles yields a single request
        cpu_addr = 23'h000003; cpu_rd = 1;
        push_txn(1'b0, 23'h000003, 2'b10, 16'h0000);
        cnt = 0; prev = 0;
        fork
            serve(2, 16'h5500, waited);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_req && !prev) cnt++;
                prev = mem_req;
            end
        join
        cpu_rd = 0;
        check("held_req_count", 32'(cnt), 32'd1);
        check("held_cpu_din", 32'(cpu_din), 32'h55);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a CPU write is in flight
        cpu_addr = 23'h000005; cpu_wdata = 8'h99; cpu_wr = 1;
        waited = 0;
        while (!mem_req && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_req_seen", 32'(mem_req), 32'd1);
        reset = 1;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_mem_we", 32'(mem_we), 32'd0);
        check("rst_mid_mem_be", 32'(mem_be), 32'd0);
        check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mid_ready", 32'(cpu_ready), 32'd1);
        check("rst_mid_cpu_din", 32'(cpu_din), 32'hFF);
        check("rst_mid_overrun", 32'(vid_overrun), 32'd0);
        @(negedge clk);
        reset = 0; cpu_wr = 0;
        @(negedge clk);
        mem_rdata = 16'h1234; mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        @(negedge clk);
        check("late_ack_cpu_din", 32'(cpu_din), 32'hFF);
        check("late_ack_vram_din", 32'(vram_din), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);

        // Non-zero video base on the second instance
        vid_strobe1 = 1; vram_addr1 = 15'h7FFF;
        @(negedge clk);
        vid_strobe1 = 0;
        waited = 0;
        while (!mem_req1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("base_req", 32'(mem_req1), 32'd1);
        check("base_addr", 32'(mem_addr1), 32'h04FFFE);
        check("base_be", 32'(mem_be1), 32'd3);
        mem_ack1 = 1;
        @(negedge clk);
        mem_ack1 = 0;
        check("base_req_drop", 32'(mem_req1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
